// File: rtl/sd_spi_byte_xfer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_byte_xfer_if
//  Description : Bundles the byte-transfer handshake from the SD controller
//                and the SD card SPI pins into one interface.
//                  start, tx_byte, fast_mode : transfer request and byte to send
//                  cs_assert                 : chip-select request (1 = selected)
//                  spi_miso                  : card data out
//                  spi_mosi, spi_sclk        : card data in, SPI clock
//                  spi_cs                    : active-low chip select
//                  rx_byte, done, busy       : received byte and status
//                The master modport is the controller side. It also drives
//                spi_miso, because that pin comes from the card and not from
//                the transceiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_spi_byte_xfer_if;
   logic       start;
   logic [7:0] tx_byte;
   logic       fast_mode;
   logic       cs_assert;
   logic       spi_miso;
   logic       spi_mosi;
   logic       spi_sclk;
   logic       spi_cs;
   logic [7:0] rx_byte;
   logic       done;
   logic       busy;

   modport master (
      output start, tx_byte, fast_mode, cs_assert, spi_miso,
      input  spi_mosi, spi_sclk, spi_cs, rx_byte, done, busy
   );

   modport slave (
      input  start, tx_byte, fast_mode, cs_assert, spi_miso,
      output spi_mosi, spi_sclk, spi_cs, rx_byte, done, busy
   );
endinterface
`default_nettype wire

// File: rtl/sd_spi_byte_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_byte_xfer
//  Description : SPI mode-0 byte transceiver for an SD card. It shifts one
//                byte out on MOSI, MSB first. MISO is captured on each rising
//                edge of SCLK. The received byte is returned together with a
//                one-cycle done pulse. The SCLK half-period is CLK_DIV_SLOW or
//                CLK_DIV_FAST clk cycles, selected per byte by fast_mode.
//                SPI_CS is the registered inverse of cs_assert and does not
//                depend on the transfer state.
//  Ports       : clk - system clock, rising edge
//                rst - synchronous active-high reset
//                bus - sd_spi_byte_xfer_if.slave (request, pins, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_byte_xfer #(
   parameter int CLK_DIV_SLOW = 125,
   parameter int CLK_DIV_FAST = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   sd_spi_byte_xfer_if.slave     bus
);

   localparam logic [7:0] DIV_SLOW = 8'(CLK_DIV_SLOW);
   localparam logic [7:0] DIV_FAST = 8'(CLK_DIV_FAST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] hc;        // half-period counter
   logic [7:0] div;       // divider latched at start
   logic [2:0] bit_cnt;
   logic [6:0] tx_sr;     // remaining TX bits; bit 6 is the next MOSI bit
   logic [7:0] rx_sr;
   logic       sclk;
   logic       mosi;
   logic       cs_n;
   logic [7:0] rx_byte;
   logic       done;
   logic       busy;

   wire logic  half_end = (hc == (div - 8'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         hc      <= 8'd0;
         div     <= 8'd0;
         bit_cnt <= 3'd0;
         tx_sr   <= 7'd0;
         rx_sr   <= 8'd0;
         sclk    <= 1'b0;
         mosi    <= 1'b1;
         cs_n    <= 1'b1;
         rx_byte <= 8'd0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         cs_n <= ~bus.cs_assert;
         done <= 1'b0;
         case (state)
            IDLE: begin
               sclk <= 1'b0;
               mosi <= 1'b1;
               if (bus.start) begin
                  // MSB goes straight onto MOSI. The shift register holds
                  // only the seven bits still to be sent.
                  tx_sr   <= bus.tx_byte[6:0];
                  mosi    <= bus.tx_byte[7];
                  div     <= bus.fast_mode ? DIV_FAST : DIV_SLOW;
                  bit_cnt <= 3'd0;
                  hc      <= 8'd0;
                  busy    <= 1'b1;
                  state   <= LOW;
               end
            end

            LOW: begin
               if (half_end) begin
                  // MISO is sampled on the same edge that raises SCLK.
                  sclk  <= 1'b1;
                  hc    <= 8'd0;
                  rx_sr <= {rx_sr[6:0], bus.spi_miso};
                  state <= HIGH;
               end else begin
                  hc <= hc + 8'd1;
               end
            end

            HIGH: begin
               if (half_end) begin
                  sclk    <= 1'b0;
                  hc      <= 8'd0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt != 3'd7) begin
                     mosi  <= tx_sr[6];
                     tx_sr <= {tx_sr[5:0], 1'b1};
                     state <= LOW;
                  end else begin
                     rx_byte <= rx_sr;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     mosi    <= 1'b1;
                     state   <= IDLE;
                  end
               end else begin
                  hc <= hc + 8'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.spi_sclk = sclk;
   assign bus.spi_mosi = mosi;
   assign bus.spi_cs   = cs_n;
   assign bus.rx_byte  = rx_byte;
   assign bus.done     = done;
   assign bus.busy     = busy;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_byte_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_byte_xfer
//  Description : Self-checking bench for sd_spi_byte_xfer. Uses a vector
//                table, randomised transfers checked against a byte-level
//                reference model, and hand-written sequences for reset,
//                back-to-back transfers and chip-select.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_byte_xfer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sd_spi_byte_xfer_if bus();

   sd_spi_byte_xfer #(
      .CLK_DIV_SLOW (125),
      .CLK_DIV_FAST (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic loop_en  = 1'b0;
   logic miso_drv = 1'b1;
   logic cs_drv   = 1'b0;

   // Card model: either loopback or a bit the bench presents.
   always_comb bus.spi_miso = loop_en ? bus.spi_mosi : miso_drv;

   typedef struct {
      logic [7:0] tx;
      logic       fast;
      logic       loop;
      logic [7:0] pat;
      logic       noise;
      logic [7:0] exp_rx;
      int         exp_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model at byte level: the half-period comes from the rate
   // select, a byte takes 16 half-periods, and the received byte is whatever
   // the card presented.
   function automatic int model_div(input logic fast);
      return fast ? 2 : 125;
   endfunction

   function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic loop,
                                           input logic [7:0] pat);
      return loop ? tx : pat;
   endfunction

   task automatic xfer(input string tag, input logic [7:0] tx, input logic fast,
                       input logic loop, input logic [7:0] pat, input logic noise,
                       input logic [7:0] exp_rx, input int exp_lat);
      int         d          = model_div(fast);
      int         rises      = 0;
      int         lat        = -1;
      int         last_rise  = -1;
      int         i          = 0;
      logic [7:0] mosi_seen  = 8'd0;
      logic [7:0] rx_at_done = 8'd0;
      logic       prev_sclk  = 1'b0;
      logic       bad_period = 1'b0;
      logic       overlap    = 1'b0;
      logic       cs_bad     = 1'b0;
      logic       got_done   = 1'b0;

      loop_en       = loop;
      miso_drv      = pat[7];
      bus.start     = 1'b1;
      bus.tx_byte   = tx;
      bus.fast_mode = fast;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);

      while (!got_done && i < 5000) begin
         if (bus.done && bus.busy) overlap = 1'b1;
         if (bus.spi_sclk && !prev_sclk) begin
            mosi_seen = {mosi_seen[6:0], bus.spi_mosi};
            if (last_rise >= 0 && (i - last_rise) != 2 * d) bad_period = 1'b1;
            last_rise = i;
            rises++;
            miso_drv = (rises < 8) ? pat[7 - rises] : 1'b1;
         end
         prev_sclk = bus.spi_sclk;

         if (bus.spi_cs !== ~cs_drv) cs_bad = 1'b1;
         if (noise) begin
            cs_drv        = 1'($urandom);
            bus.cs_assert = cs_drv;
         end

         if (bus.done) begin
            got_done   = 1'b1;
            lat        = i;
            rx_at_done = bus.rx_byte;
            bus.start  = 1'b0;
         end else begin
            if (noise && bus.busy) begin
               bus.start     = 1'($urandom);
               bus.tx_byte   = 8'($urandom);
               bus.fast_mode = 1'($urandom);
            end
            i++;
            @(negedge clk);
         end
      end
      bus.start = 1'b0;

      check({tag, "_done_seen"}, 32'(got_done), 32'd1);
      check({tag, "_latency"},   32'(lat), 32'(exp_lat));
      check({tag, "_rx"},        32'(rx_at_done), 32'(exp_rx));
      check({tag, "_mosi_bits"}, 32'(mosi_seen), 32'(tx));
      check({tag, "_rises"},     32'(rises), 32'd8);
      check({tag, "_period"},    32'(bad_period), 32'd0);
      check({tag, "_overlap"},   32'(overlap), 32'd0);
      check({tag, "_cs_follow"}, 32'(cs_bad), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_idle_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_rx_hold"},    32'(bus.rx_byte), 32'(exp_rx));
      cs_drv        = 1'b0;
      bus.cs_assert = 1'b0;
      @(negedge clk);
   endtask

   task automatic back_to_back();
      int         i  = 0;
      int         d1 = -1;
      int         d2 = -1;
      logic [7:0] r1 = 8'd0;
      logic [7:0] r2 = 8'd0;
      loop_en       = 1'b1;
      bus.tx_byte   = 8'h12;
      bus.fast_mode = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      while (d2 < 0 && i < 500) begin
         if (bus.done) begin
            if (d1 < 0) begin
               d1 = i;
               r1 = bus.rx_byte;
               bus.tx_byte = 8'h34;
            end else begin
               d2 = i;
               r2 = bus.rx_byte;
            end
         end else if (d1 >= 0 && bus.busy) begin
            bus.start = 1'b0;
         end
         i++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("b2b_first_rx",  32'(r1), 32'h12);
      check("b2b_second_rx", 32'(r2), 32'h34);
      check("b2b_gap",       32'(d2 - d1), 32'd33);
   endtask

   task automatic reset_mid();
      logic saw_done = 1'b0;
      loop_en       = 1'b1;
      bus.tx_byte   = 8'h5A;
      bus.fast_mode = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_sclk", 32'(bus.spi_sclk), 32'd0);
      check("rstmid_mosi", 32'(bus.spi_mosi), 32'd1);
      check("rstmid_cs",   32'(bus.spi_cs),   32'd1);
      check("rstmid_busy", 32'(bus.busy),     32'd0);
      check("rstmid_rx",   32'(bus.rx_byte),  32'd0);
      rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      check("rstmid_no_done", 32'(saw_done), 32'd0);
   endtask

   task automatic cs_idle();
      cs_drv = 1'b1; bus.cs_assert = 1'b1;
      check("cs_latency_hold", 32'(bus.spi_cs), 32'd1);
      @(negedge clk);
      check("cs_assert_low",   32'(bus.spi_cs), 32'd0);
      cs_drv = 1'b0; bus.cs_assert = 1'b0;
      check("cs_release_hold", 32'(bus.spi_cs), 32'd0);
      @(negedge clk);
      check("cs_release_high", 32'(bus.spi_cs), 32'd1);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.tx_byte   = 8'h00;
      bus.fast_mode = 1'b0;
      bus.cs_assert = 1'b0;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA5, 32};
      vecs[1] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF, 2000};
      vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h00, 1'b1, 8'h3C, 32};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A, 32};
      vecs[4] = '{8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32};
      vecs[5] = '{8'h7E, 1'b1, 1'b0, 8'hC3, 1'b1, 8'hC3, 32};

      repeat (3) @(negedge clk);
      check("reset_sclk", 32'(bus.spi_sclk), 32'd0);
      check("reset_mosi", 32'(bus.spi_mosi), 32'd1);
      check("reset_cs",   32'(bus.spi_cs),   32'd1);
      check("reset_rx",   32'(bus.rx_byte),  32'd0);
      check("reset_done", 32'(bus.done),     32'd0);
      check("reset_busy", 32'(bus.busy),     32'd0);
      rst = 1'b0;
      @(negedge clk);

      cs_idle();

      for (int k = 0; k < 6; k++)
         xfer($sformatf("vec%0d", k), vecs[k].tx, vecs[k].fast, vecs[k].loop,
              vecs[k].pat, vecs[k].noise, vecs[k].exp_rx, vecs[k].exp_lat);

      for (int k = 0; k < 16; k++) begin
         logic [7:0] tx   = 8'($urandom);
         logic [7:0] pat  = 8'($urandom);
         logic       loop = 1'($urandom);
         logic       fast = (k < 14);
         xfer($sformatf("rnd%0d", k), tx, fast, loop, pat, 1'b1,
              model_rx(tx, loop, pat), 16 * model_div(fast));
      end

      back_to_back();
      repeat (40) @(negedge clk);
      reset_mid();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sd_spi_byte_xfer.md
Name: sd_spi_byte_xfer

Overview:
- SPI-mode-0 byte transceiver that sits directly below the SD controller and drives the card pins.
- The SD command/initialisation FSM hands it one byte at a time. It shifts the byte out on MOSI, captures MISO, and returns the received byte with a one-cycle Done strobe.
- It supports a slow SCLK rate for card initialisation (≤400 kHz) and a fast rate for data transfer. Chip-select is driven separately under controller control.

Parameters:
- CLK_DIV_SLOW, 125, MasterCLK cycles per SCLK half-period in slow mode (100 MHz -> 400 kHz); legal range 1..255.
- CLK_DIV_FAST, 2, MasterCLK cycles per SCLK half-period in fast mode; legal range 1..255.

Ports:
- MasterCLK  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a byte transfer; sampled only when Busy=0.
- TxByte  in  8  byte to send, MSB first; latched on an accepted Start.
- FastMode  in  1  1 = use CLK_DIV_FAST, 0 = use CLK_DIV_SLOW; latched on an accepted Start.
- CSAssert  in  1  1 = card selected.
- SPI_MISO  in  1  card data out.
- SPI_MOSI  out  1  card data in.
- SPI_SCLK  out  1  SPI clock; idles low.
- SPI_CS  out  1  active-low chip select.
- RxByte  out  8  last received byte; valid from Done onward.
- Done  out  1  one-cycle pulse when a transfer completes.
- Busy  out  1  high while a transfer is in progress.

Behaviour:
- Reset values: SPI_SCLK=0, SPI_MOSI=1, SPI_CS=1, RxByte=0x00, Done=0, Busy=0. All internal counters and state return to 0/IDLE.
- SPI_CS is the registered value of ~CSAssert (one-cycle latency). It is independent of the transfer FSM and is never altered by the block itself.
- States are IDLE, LOW, HIGH. D denotes the latched divider and hc the half-period counter.
- IDLE:
  - SCLK=0, MOSI=1.
  - Start=1 at edge k: latch TxByte into the shift register, latch D, set bit count=0 and hc=0, set Busy=1, MOSI=TxByte[7], go to LOW. All of these are visible from cycle k+1.
- LOW:
  - SCLK=0; hc increments each cycle.
  - When hc reaches D-1: SCLK->1, hc->0, shift SPI_MISO into the LSB of the receive register, go to HIGH. MISO is sampled on the same edge that raises SCLK.
- HIGH:
  - SCLK=1; hc increments each cycle.
  - When hc reaches D-1: SCLK->0, hc->0, bit count+1.
  - If bit count was <7: MOSI takes the next TX bit; go to LOW.
  - If bit count was 7: RxByte<=receive register, Done=1 for that single cycle, Busy=0, MOSI=1; go to IDLE.
- Latency: Done is asserted exactly 16*D cycles after Busy rises. Each bit takes 2*D cycles and there are exactly 8 SCLK rising edges per byte.
- Start with Busy=1 is ignored. TxByte and FastMode changes during a transfer have no effect.
- Back-to-back transfers: Start asserted in the Done cycle is accepted (the FSM is IDLE then). Busy returns high the next cycle, giving a 1-cycle SCLK-low gap between bytes.
- Done and Busy are never high simultaneously.
- RxByte holds its value until the next Done.
- Reset asserted mid-transfer: abort immediately to reset values; no Done is generated and RxByte is cleared.
- Divider width is 8 bits. D=1 gives SCLK = MasterCLK/2.

Test Plan:
- Loopback, fast: FastMode=1, CLK_DIV_FAST=2, SPI_MISO tied to SPI_MOSI, TxByte=0xA5, Start for 1 cycle.
  - Busy high for 32 cycles; Done is a 1-cycle pulse at cycle 32 after Busy rises.
  - RxByte=0xA5; MOSI at each SCLK rise reads 1,0,1,0,0,1,0,1.
- Slow rate, MISO held 1: FastMode=0, CLK_DIV_SLOW=125, TxByte=0xFF.
  - SCLK period is 250 cycles with 8 rising edges; Done at 2000 cycles; RxByte=0xFF.
- Start ignored while busy: mid-transfer of 0x3C, pulse Start with TxByte=0x99.
  - Only one Done; MOSI pattern matches 0x3C only.
- Back-to-back: Start held high across two transfers with TxByte=0x12, then 0x34, loopback, D=2.
  - Two Done pulses 33 cycles apart; RxByte=0x12, then 0x34.
- Reset mid-transfer: assert Reset at cycle 10 of a 0x5A transfer.
  - The next cycle shows SCLK=0, MOSI=1, CS=1, Busy=0, RxByte=0x00; no Done ever follows.
- CS control: toggle CSAssert 0->1->0 while idle and while busy.
  - SPI_CS follows ~CSAssert with 1-cycle latency; the transfer is unaffected.
